alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (ctrl codes 0001 add, 0010 sub, 0100 or, 1000 pass-B) among NREQ requesters.
//  Round-robin grant, valid/ready request handshake, registered result/zero response tagged with requester id.
//  Sits between datapath clients (e.g. branch-compare, address-gen units) and the single ALU instance.
// PARAMETERS
//  NREQ  2   number of requesters (2..8)
//  IDW   1   width of requester id, >= clog2(NREQ)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          async, active-high reset
//  req_valid  in   NREQ       per-requester request valid
//  req_ready  out  NREQ       one-hot accept strobe, high only in the accept cycle
//  req_a      in   32*NREQ    operand A, requester i at [32*i+31:32*i]
//  req_b      in   32*NREQ    operand B, same packing
//  req_ctrl   in   4*NREQ     ALU control code, requester i at [4*i+3:4*i]
//  alu_a      out  32         to shared ALU A
//  alu_b      out  32         to shared ALU B
//  alu_ctrl   out  4          to shared ALU ctrl
//  alu_result in   32         from shared ALU Result
//  alu_zero   in   1          from shared ALU Zero
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer ready
//  rsp_id     out  IDW        index of the requester the response belongs to
//  rsp_result out  32         registered ALU result
//  rsp_zero   out  1          registered ALU zero flag
//  rsp_err    out  1          1 = illegal ctrl code, result forced to 0
//  busy       out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0,
//   alu_a=0, alu_b=0, alu_ctrl=0, last_grant=NREQ-1 (requester 0 wins first). In-flight op is dropped.
//  FSM IDLE -> EXEC -> DONE -> IDLE.
//  IDLE: if any req_valid, grant first valid index searching last_grant+1, +2, ... modulo NREQ.
//   Grant cycle: req_ready[g]=1 (combinational on req_valid), latch A/B/ctrl/id into op regs, go EXEC.
//   Request is consumed only when req_valid[g] & req_ready[g]. No request: stay IDLE.
//  EXEC (1 cycle): alu_a/alu_b/alu_ctrl driven from op regs (all zero in every other state).
//   Edge: capture rsp_result=alu_result, rsp_zero=alu_zero, rsp_err=0; go DONE.
//   Illegal ctrl (not 0001/0010/0100/1000): ALU ports stay 0, capture result=0, zero=1, err=1.
//  DONE: rsp_valid=1; rsp_* stable until rsp_valid & rsp_ready; then last_grant=rsp_id, go IDLE.
//  Latency: accept at cycle T -> rsp_valid at T+2 (earliest). Throughput: 1 op / 3 cycles at full rate.
//  req_ready is 0 in EXEC and DONE; requesters hold valid and operands until accepted.
//  A requester dropping req_valid before grant is legal (no grant, no response).
//  last_grant updates only on response handshake, so a stalled response does not advance fairness.
//  Result arithmetic is the ALU's: 32-bit modulo, no overflow flag.
// TESTING
//  1) Reset, req_valid=01, A=5 B=7 ctrl=0001 -> req_ready=01 at T, rsp_valid at T+2, result=12, zero=0, id=0.
//  2) Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; each requester every 6 cycles.
//  3) A=B=0x8000_0000 ctrl=0010 -> result=0, zero=1; A=0xFFFF_FFFF B=1 ctrl=0001 -> result=0, zero=1.
//  4) ctrl=0011 -> alu_ctrl stays 0000, rsp_err=1, result=0, zero=1.
//  5) rsp_ready=0 for 5 cycles in DONE -> rsp_* held, req_ready=0 throughout, no grant until handshake.
//  6) reset asserted during EXEC -> outputs immediately at reset values; after release req 0 wins first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters.
// Each accepted op spends one cycle on the ALU, then its registered response is held until taken.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [32*NREQ-1:0]   req_a_i,
  input  logic [32*NREQ-1:0]   req_b_i,
  input  logic [4*NREQ-1:0]    req_ctrl_i,
  output logic [31:0]          alu_a_o,
  output logic [31:0]          alu_b_o,
  output logic [3:0]           alu_ctrl_o,
  input  logic [31:0]          alu_result_i,
  input  logic                 alu_zero_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_zero_o,
  output logic                 rsp_err_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] last_q, op_id_q, rsp_id_q, gnt_id, idx;
  logic [31:0] op_a_q, op_b_q, rsp_result_q;
  logic [3:0] op_ctrl_q;
  logic rsp_zero_q, rsp_err_q, gnt_found, legal, drive;
  // Scan from farthest to nearest so the nearest valid after last_q wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign legal = (op_ctrl_q == 4'b0001) || (op_ctrl_q == 4'b0010) ||
                 (op_ctrl_q == 4'b0100) || (op_ctrl_q == 4'b1000);
  assign drive = (state_q == EXEC) && legal;
  assign alu_a_o = drive ? op_a_q : '0;
  assign alu_b_o = drive ? op_b_q : '0;
  assign alu_ctrl_o = drive ? op_ctrl_q : '0;
  assign req_ready_o = (!reset_i && state_q == IDLE && gnt_found) ? NREQ'(1) << gnt_id : '0;
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_id_o = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o = rsp_zero_q;
  assign rsp_err_o = rsp_err_q;
  assign busy_o = (state_q != IDLE);
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && gnt_found) ? EXEC :
              (state_q == EXEC) ? DONE :
              (state_q == DONE && rsp_ready_i) ? IDLE : state_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q <= IDW'(NREQ - 1);
      op_id_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_ctrl_q <= '0;
      rsp_id_q <= '0;
      rsp_result_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_found) begin
        op_id_q <= gnt_id;
        op_a_q <= req_a_i[32*gnt_id +: 32];
        op_b_q <= req_b_i[32*gnt_id +: 32];
        op_ctrl_q <= req_ctrl_i[4*gnt_id +: 4];
      end
      if (state_q == EXEC) begin
        rsp_id_q <= op_id_q;
        rsp_result_q <= legal ? alu_result_i : '0;
        rsp_zero_q <= legal ? alu_zero_i : 1'b1;
        rsp_err_q <= !legal;
      end
      if (state_q == DONE && rsp_ready_i) last_q <= rsp_id_q;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors plus hand-written fairness, stall and reset sequences.
module tb_alu_share_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready;
  logic [63:0] req_a = '0, req_b = '0;
  logic [7:0] req_ctrl = '0;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0] alu_ctrl;
  logic alu_zero, rsp_valid, rsp_ready = 1'b0, rsp_zero, rsp_err, busy;
  logic [0:0] rsp_id;
  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0] ctrl;
    logic [31:0] res;
    logic zero, err;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // Stand-in for the shared ALU instance.
  always_comb begin
    alu_result = (alu_ctrl == 4'b0001) ? alu_a + alu_b :
                 (alu_ctrl == 4'b0010) ? alu_a - alu_b :
                 (alu_ctrl == 4'b0100) ? alu_a | alu_b :
                 (alu_ctrl == 4'b1000) ? alu_b : 32'h0;
    alu_zero = (alu_result == 32'h0);
  end

  alu_share_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_ctrl_i(req_ctrl),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input int r, input vec_t v);
    @(negedge clk);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_a[32*r +: 32] = v.a;
    req_b[32*r +: 32] = v.b;
    req_ctrl[4*r +: 4] = v.ctrl;
    rsp_ready = 1'b1;
    #1;
    chk("grant_ready", 32'(req_ready), 32'(1 << r));
    chk("idle_not_busy", 32'(busy), 0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("exec_alu_ctrl", 32'(alu_ctrl), v.err ? 0 : 32'(v.ctrl));
    chk("exec_alu_a", alu_a, v.err ? 0 : v.a);
    chk("exec_no_rsp", 32'(rsp_valid), 0);
    chk("exec_ready_low", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    chk("done_valid", 32'(rsp_valid), 1);
    chk("done_result", rsp_result, v.res);
    chk("done_zero", 32'(rsp_zero), 32'(v.zero));
    chk("done_err", 32'(rsp_err), 32'(v.err));
    chk("done_id", 32'(rsp_id), 32'(r));
  endtask

  initial begin
    vecs[0] = '{32'd5, 32'd7, 4'b0001, 32'd12, 1'b0, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 4'b0010, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h1, 4'b0001, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{32'hF0, 32'h0F, 4'b0100, 32'hFF, 1'b0, 1'b0};
    vecs[4] = '{32'h1234, 32'hABCD, 4'b1000, 32'hABCD, 1'b0, 1'b0};
    vecs[5] = '{32'd3, 32'd5, 4'b0010, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[6] = '{32'd5, 32'd7, 4'b0011, 32'h0, 1'b1, 1'b1};
    vecs[7] = '{32'd5, 32'd7, 4'b0000, 32'h0, 1'b1, 1'b1};
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_op(i % 2, vecs[i]);

    // Both requesters valid continuously: grants alternate 0,1,0,1.
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req_b = {32'd22, 32'd11};
    req_ctrl = {4'b1000, 4'b1000};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      chk("rr_grant", 32'(req_ready), (n % 2) ? 2 : 1);
      @(negedge clk);
      #1;
      chk("rr_exec_ready", 32'(req_ready), 0);
      @(negedge clk);
      #1;
      chk("rr_id", 32'(rsp_id), 32'(n % 2));
      chk("rr_result", rsp_result, (n % 2) ? 22 : 11);
      @(negedge clk);
      #1;
    end

    // Stalled response: held 5 cycles, no new grant, fairness not advanced.
    chk("stall_grant", 32'(req_ready), 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_result", rsp_result, 11);
      chk("stall_id", 32'(rsp_id), 0);
      chk("stall_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_stall_grant", 32'(req_ready), 2);

    // Reset during EXEC, then requester 0 wins first.
    @(negedge clk);
    #1;
    chk("exec_b", alu_b, 22);
    reset = 1'b1;
    #1;
    chk("arst_alu_b", alu_b, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_first_grant", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("arst_rsp_id", 32'(rsp_id), 0);
    chk("arst_rsp_result", rsp_result, 11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
